// File: rtl/store_queue.sv
// store_queue: in-order pending-store buffer between execute and the memory
// write port. Entries drain oldest-first, and a combinational overlap check
// flags any 4-byte load that touches bytes of a not-yet-committed store.
module store_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enq_valid,
   output logic             enq_ready,
   input  logic [31:0]      enq_addr,
   input  logic [3:0]       enq_width,
   input  logic [31:0]      enq_data,
   input  logic             drain_en,
   output logic             mem_write_en,
   output logic [3:0]       mem_write_width,
   output logic [31:0]      mem_addr_write,
   output logic [31:0]      mem_write_data,
   input  logic [31:0]      ld_addr,
   output logic             ld_hazard,
   output logic             enq_error,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  width;
      logic [31:0] data;
   } entry_t;

   entry_t           sq_mem [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic             enq_fire, enq_ok, enq_push, deq_pop;
   logic [DEPTH-1:0] hit;

   // Full check uses registered count only, so a drain never frees a slot
   // for an enqueue in the same cycle.
   assign enq_ready = (count != CNT_W'(DEPTH));
   assign enq_fire  = enq_valid && enq_ready;
   assign enq_ok    = (enq_width == 4'd1) ||
                      (enq_width == 4'd2 && !enq_addr[0]) ||
                      (enq_width == 4'd4 && enq_addr[1:0] == 2'b00);
   assign enq_push  = enq_fire && enq_ok;
   assign deq_pop   = mem_write_en;

   assign mem_write_en    = drain_en && (count != '0);
   assign mem_write_width = sq_mem[head].width;
   assign mem_addr_write  = sq_mem[head].addr;
   assign mem_write_data  = sq_mem[head].data;

   // Pointers, occupancy and the one-cycle error flag for rejected requests.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         enq_error <= 1'b0;
      end else begin
         if (enq_push) tail <= tail + 1'b1;
         if (deq_pop)  head <= head + 1'b1;
         count     <= count + CNT_W'(enq_push) - CNT_W'(deq_pop);
         enq_error <= enq_fire && !enq_ok;
      end
   end

   // Entry payloads are never reset; validity comes from head/count.
   always_ff @(posedge clk) begin
      if (enq_push) sq_mem[tail] <= '{addr: enq_addr, width: enq_width, data: enq_data};
   end

   // Per-entry overlap of [addr, addr+width) with [ld_addr, ld_addr+4),
   // done in 33 bits so range ends near 2^32 never wrap.
   for (genvar i = 0; i < DEPTH; i++) begin : g_haz
      logic [PTR_W-1:0] offset;
      logic             live;
      logic [32:0]      s_lo, s_hi, l_lo, l_hi;
      assign offset = PTR_W'(i) - head;
      assign live   = CNT_W'(offset) < count;
      assign s_lo   = {1'b0, sq_mem[i].addr};
      assign s_hi   = s_lo + 33'(sq_mem[i].width);
      assign l_lo   = {1'b0, ld_addr};
      assign l_hi   = l_lo + 33'd4;
      assign hit[i] = live && (s_lo < l_hi) && (l_lo < s_hi);
   end

   assign ld_hazard = |hit;

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
module tb_store_queue;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clk, reset;
   logic             enq_valid, enq_ready, drain_en;
   logic [31:0]      enq_addr, enq_data, ld_addr;
   logic [3:0]       enq_width;
   logic             mem_write_en, ld_hazard, enq_error;
   logic [3:0]       mem_write_width;
   logic [31:0]      mem_addr_write, mem_write_data;
   logic [CNT_W-1:0] count;

   store_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_addr(enq_addr), .enq_width(enq_width), .enq_data(enq_data),
      .drain_en(drain_en), .mem_write_en(mem_write_en),
      .mem_write_width(mem_write_width), .mem_addr_write(mem_addr_write),
      .mem_write_data(mem_write_data), .ld_addr(ld_addr),
      .ld_hazard(ld_hazard), .enq_error(enq_error), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, input logic dr, input logic [31:0] ld);
      enq_valid = v; enq_addr = a; enq_width = w; enq_data = d;
      drain_en = dr; ld_addr = ld;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b1, 32'h100, 4'd4, 32'h1, 1'b1, 32'h100);
      tick(); tick();
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_ready", 64'(enq_ready), 64'd1);
      chk("rst_we", 64'(mem_write_en), 64'd0);
      chk("rst_haz", 64'(ld_hazard), 64'd0);
      chk("rst_err", 64'(enq_error), 64'd0);
      drive(1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 32'h0);
      reset = 1'b0;
      tick();
   endtask

   // Directed table: inputs applied for one cycle, outputs checked before the edge.
   typedef struct {
      logic v; logic [31:0] a; logic [3:0] w; logic [31:0] d; logic dr; logic [31:0] ld;
      int cnt; logic rdy; logic we; logic haz; logic err; logic [31:0] ma; logic [31:0] md;
   } vec_t;
   vec_t tv[18];

   // Reference model: ordered list of pending stores.
   typedef struct { logic [31:0] a; logic [3:0] w; logic [31:0] d; } ent_t;
   ent_t mq[$];
   logic m_err;

   function automatic logic m_hazard(input logic [31:0] ld);
      longint la, le, sa, se;
      la = longint'(ld); le = la + 4;
      foreach (mq[i]) begin
         sa = longint'(mq[i].a); se = sa + longint'(mq[i].w);
         if (sa < le && la < se) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic logic legal(input logic [31:0] a, input logic [3:0] w);
      int wi;
      wi = int'(w);
      if (wi == 1) return 1'b1;
      if (wi == 2) return (a % 2) == 0;
      if (wi == 4) return (a % 4) == 0;
      return 1'b0;
   endfunction

   initial begin
      reset = 1'b1;
      drive(1'b0, 32'h0, 4'd0, 32'h0, 1'b0, 32'h0);
      #2;
      do_reset();

      //        v     addr         w     data           dr    ld           cnt rdy  we    haz   err   maddr        mdata
      tv[0]  = '{1'b1, 32'h100, 4'd4, 32'hDEADBEEF, 1'b1, 32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
      tv[1]  = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b1, 32'h100, 1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF};
      tv[2]  = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b0, 32'h100, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
      tv[3]  = '{1'b1, 32'h101, 4'd2, 32'h11,       1'b0, 32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
      tv[4]  = '{1'b1, 32'h102, 4'd4, 32'h22,       1'b0, 32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   32'h0};
      tv[5]  = '{1'b1, 32'h100, 4'd3, 32'h33,       1'b0, 32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   32'h0};
      tv[6]  = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b0, 32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,   32'h0};
      tv[7]  = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b0, 32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
      tv[8]  = '{1'b1, 32'h203, 4'd1, 32'hAB,       1'b0, 32'h200, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
      tv[9]  = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b0, 32'h200, 1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   32'h0};
      tv[10] = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b0, 32'h204, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
      tv[11] = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b0, 32'h1FD, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
      tv[12] = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b0, 32'h1FE, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
      tv[13] = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b1, 32'h200, 1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h203, 32'hAB};
      tv[14] = '{1'b1, 32'h204, 4'd2, 32'h1234,     1'b0, 32'h200, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
      tv[15] = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b0, 32'h200, 1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};
      tv[16] = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b1, 32'h203, 1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h204, 32'h1234};
      tv[17] = '{1'b0, 32'h0,   4'd0, 32'h0,        1'b0, 32'h0,   0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   32'h0};

      foreach (tv[i]) begin
         drive(tv[i].v, tv[i].a, tv[i].w, tv[i].d, tv[i].dr, tv[i].ld);
         #1;
         chk($sformatf("tv%0d_count", i), 64'(count), 64'(tv[i].cnt));
         chk($sformatf("tv%0d_ready", i), 64'(enq_ready), 64'(tv[i].rdy));
         chk($sformatf("tv%0d_we", i), 64'(mem_write_en), 64'(tv[i].we));
         chk($sformatf("tv%0d_haz", i), 64'(ld_hazard), 64'(tv[i].haz));
         chk($sformatf("tv%0d_err", i), 64'(enq_error), 64'(tv[i].err));
         if (tv[i].we) begin
            chk($sformatf("tv%0d_maddr", i), 64'(mem_addr_write), 64'(tv[i].ma));
            chk($sformatf("tv%0d_mdata", i), 64'(mem_write_data), 64'(tv[i].md));
         end
         tick();
      end

      // Fill to full, hold a fifth request, then drain with it still pending.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h300 + 32'(4*i), 4'd4, 32'hA0 + 32'(i), 1'b0, 32'h0);
         tick();
      end
      drive(1'b1, 32'h310, 4'd4, 32'hA4, 1'b0, 32'h0);
      #1;
      chk("full_count", 64'(count), 64'd4);
      chk("full_ready", 64'(enq_ready), 64'd0);
      tick();
      chk("held_count", 64'(count), 64'd4);
      drain_en = 1'b1;
      #1;
      chk("full_drain_we", 64'(mem_write_en), 64'd1);
      chk("drain0_addr", 64'(mem_addr_write), 64'h300);
      tick();
      chk("full_drain_count", 64'(count), 64'd3);
      chk("drain1_addr", 64'(mem_addr_write), 64'h304);
      tick();
      chk("held_accept_count", 64'(count), 64'd3);
      enq_valid = 1'b0;
      for (int i = 2; i < 5; i++) begin
         #1;
         chk($sformatf("drain%0d_we", i), 64'(mem_write_en), 64'd1);
         chk($sformatf("drain%0d_addr", i), 64'(mem_addr_write), 64'(32'h300 + 32'(4*i)));
         chk($sformatf("drain%0d_data", i), 64'(mem_write_data), 64'(32'hA0 + 32'(i)));
         tick();
      end
      chk("drained_count", 64'(count), 64'd0);
      chk("drained_we", 64'(mem_write_en), 64'd0);

      // Asynchronous reset mid-cycle with three entries pending.
      drain_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h500 + 32'(4*i), 4'd4, 32'h5, 1'b0, 32'h0);
         tick();
      end
      drive(1'b0, 32'h0, 4'd0, 32'h0, 1'b1, 32'h500);
      chk("pre_areset_count", 64'(count), 64'd3);
      #1 reset = 1'b1;
      #1;
      chk("areset_count", 64'(count), 64'd0);
      chk("areset_we", 64'(mem_write_en), 64'd0);
      chk("areset_haz", 64'(ld_hazard), 64'd0);
      #1 reset = 1'b0;
      tick();
      chk("post_areset_we", 64'(mem_write_en), 64'd0);
      tick();
      chk("post_areset_count", 64'(count), 64'd0);

      // Randomized traffic against the reference model.
      do_reset();
      mq.delete();
      m_err = 1'b0;
      for (int c = 0; c < 600; c++) begin
         logic [3:0] w;
         logic [31:0] a;
         logic acc, pop;
         case ($urandom_range(0, 9))
            0, 1, 2: w = 4'd1;
            3, 4:    w = 4'd2;
            5, 6, 7: w = 4'd4;
            8:       w = 4'd3;
            default: w = 4'($urandom_range(0, 15));
         endcase
         a = 32'h400 + 32'($urandom_range(0, 15));
         if ($urandom_range(0, 3) != 0) a = a & ~32'(w - 4'd1);
         drive(1'($urandom_range(0, 1)), a, w, $urandom,
               1'($urandom_range(0, 2) == 0), 32'h3FD + 32'($urandom_range(0, 20)));
         #1;
         chk("rnd_count", 64'(count), 64'(mq.size()));
         chk("rnd_ready", 64'(enq_ready), 64'(mq.size() != DEPTH));
         chk("rnd_we", 64'(mem_write_en), 64'(drain_en && mq.size() != 0));
         chk("rnd_haz", 64'(ld_hazard), 64'(m_hazard(ld_addr)));
         chk("rnd_err", 64'(enq_error), 64'(m_err));
         if (mq.size() != 0) begin
            chk("rnd_maddr", 64'(mem_addr_write), 64'(mq[0].a));
            chk("rnd_mwidth", 64'(mem_write_width), 64'(mq[0].w));
            chk("rnd_mdata", 64'(mem_write_data), 64'(mq[0].d));
         end
         acc = enq_valid && (mq.size() != DEPTH);
         pop = drain_en && (mq.size() != 0);
         if (pop) void'(mq.pop_front());
         if (acc && legal(enq_addr, enq_width)) mq.push_back('{enq_addr, enq_width, enq_data});
         m_err = acc && !legal(enq_addr, enq_width);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
